// File: rtl/mc_core.sv
// rtl/mc_core.sv - parametrised multicycle MIPS-subset core with shared req/ready memory port
// Optional retired-instruction counter port enabled by defining MC_CORE_INSTRET_EN.
module mc_core #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            halted,
    output logic [XLEN-1:0] pc_out
`ifdef MC_CORE_INSTRET_EN
    ,
    output logic [31:0]     instret
`endif
);
    localparam int RIDX = $clog2(NREG);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                           FN_OR = 6'h25, FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        FETCH, DECODE, EX_R, EX_I, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, WB_ALU, BRANCH, JUMP, HALT
    } stateT;

    stateT           state, nextState;
    logic [XLEN-1:0] pc, aluOut, regA, regB, mdr;
    logic [31:0]     ir;
    logic [XLEN-1:0] regFile [NREG];
    // Holds off the first request until one edge after reset release.
    logic            fetchArmed;

    logic [5:0]      opcode, funct;
    logic [4:0]      rs, rt, rd;
    logic [XLEN-1:0] immExt, rRes, diff;
    logic            rFunctOk, retire, wrEn;
    logic [4:0]      wrIdx;
    logic [XLEN-1:0] wrData;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign immExt = {{(XLEN-16){ir[15]}}, ir[15:0]};
    assign diff   = regA - regB;

    function automatic logic [XLEN-1:0] rdReg(input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= NREG)
            return '0;
        return regFile[idx[RIDX-1:0]];
    endfunction

    always_comb begin
        rRes     = '0;
        rFunctOk = 1'b1;
        case (funct)
            FN_ADD:  rRes = regA + regB;
            FN_SUB:  rRes = diff;
            FN_AND:  rRes = regA & regB;
            FN_OR:   rRes = regA | regB;
            FN_SLT:  rRes = {{(XLEN-1){1'b0}}, $signed(regA) < $signed(regB)};
            default: rFunctOk = 1'b0;
        endcase
    end

    always_comb begin
        nextState = state;
        wrEn      = 1'b0;
        wrIdx     = rt;
        wrData    = aluOut;
        retire    = 1'b0;
        case (state)
            FETCH:    if (mem_req && mem_ready) nextState = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     nextState = (funct == FN_JR) ? JUMP : (rFunctOk ? EX_R : HALT);
                    OP_ADDI:      nextState = EX_I;
                    OP_LW, OP_SW: nextState = MEM_ADDR;
                    OP_BEQ, OP_BNE: nextState = BRANCH;
                    OP_J, OP_JAL: nextState = JUMP;
                    default:      nextState = HALT;
                endcase
            end
            EX_R, EX_I: nextState = WB_ALU;
            MEM_ADDR:   nextState = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:     if (mem_ready) nextState = WB_MEM;
            MEM_WR: begin
                if (mem_ready) begin
                    nextState = FETCH;
                    retire    = 1'b1;
                end
            end
            WB_MEM: begin
                wrEn      = 1'b1;
                wrData    = mdr;
                retire    = 1'b1;
                nextState = FETCH;
            end
            WB_ALU: begin
                wrEn      = 1'b1;
                wrIdx     = (opcode == OP_RTYPE) ? rd : rt;
                retire    = 1'b1;
                nextState = FETCH;
            end
            BRANCH: begin
                retire    = 1'b1;
                nextState = FETCH;
            end
            JUMP: begin
                wrEn      = (opcode == OP_JAL);
                wrIdx     = 5'd31;
                wrData    = pc;
                retire    = 1'b1;
                nextState = FETCH;
            end
            default: nextState = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            regA       <= '0;
            regB       <= '0;
            aluOut     <= '0;
            mdr        <= '0;
            fetchArmed <= 1'b0;
            for (int i = 0; i < NREG; i++) regFile[i] <= '0;
        end else begin
            state      <= nextState;
            fetchArmed <= 1'b1;
            case (state)
                FETCH: begin
                    if (mem_req && mem_ready) begin
                        ir <= mem_rdata[31:0];
                        pc <= pc + XLEN'(4);
                    end
                end
                DECODE: begin
                    regA   <= rdReg(rs);
                    regB   <= rdReg(rt);
                    aluOut <= pc + (immExt << 2);
                end
                EX_R:           aluOut <= rRes;
                EX_I, MEM_ADDR: aluOut <= regA + immExt;
                MEM_RD:         if (mem_ready) mdr <= mem_rdata;
                BRANCH:         if ((opcode == OP_BEQ) == (diff == '0)) pc <= aluOut;
                JUMP: begin
                    if (opcode == OP_RTYPE) pc <= regA;
                    else                    pc <= {pc[XLEN-1:28], ir[25:0], 2'b00};
                end
                default: ;
            endcase
            if (wrEn && wrIdx != 5'd0 && int'(wrIdx) < NREG)
                regFile[wrIdx[RIDX-1:0]] <= wrData;
        end
    end

`ifdef MC_CORE_INSTRET_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        instret <= '0;
        else if (retire) instret <= instret + 32'd1;
    end
`else
    logic unusedRetire;
    assign unusedRetire = retire;
`endif

    assign mem_req   = (state == FETCH && fetchArmed) || state == MEM_RD || state == MEM_WR;
    assign mem_we    = (state == MEM_WR);
    assign mem_addr  = (state == FETCH) ? pc : aluOut;
    assign mem_wdata = regB;
    assign halted    = (state == HALT);
    assign pc_out    = pc;
endmodule

// File: tb/tb_mc_core.sv
// tb/tb_mc_core.sv - directed self-checking bench for mc_core (both MC_CORE_INSTRET_EN builds)
module tb_mc_core;
    logic        clk = 1'b0;
    logic        rst, rst8;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    logic        req8, we8, ready8, halted8;
    logic [31:0] addr8, wdata8, rdata8, pc8;
`ifdef MC_CORE_INSTRET_EN
    logic [31:0] instret, instret8;
`endif

    logic [31:0] mem  [256];
    logic [31:0] mem8 [256];
    int          waitCycles = 0;
    int          waitCnt = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    mc_core #(.XLEN(32), .NREG(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .halted(halted), .pc_out(pc_out)
`ifdef MC_CORE_INSTRET_EN
        , .instret(instret)
`endif
    );

    mc_core #(.XLEN(32), .NREG(8), .RESET_PC(32'h0)) dut8 (
        .clk(clk), .rst(rst8), .mem_req(req8), .mem_we(we8), .mem_addr(addr8),
        .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ready(ready8),
        .halted(halted8), .pc_out(pc8)
`ifdef MC_CORE_INSTRET_EN
        , .instret(instret8)
`endif
    );

    // Memory with waitCycles stall cycles before each ready.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (waitCnt == waitCycles) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[9:2]];
                    if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                    waitCnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    waitCnt++;
                end
            end else begin
                mem_ready = 1'b0;
                waitCnt = 0;
            end
        end
    end

    initial begin
        ready8 = 1'b1;
        rdata8 = '0;
        forever begin
            @(negedge clk);
            rdata8 = mem8[addr8[9:2]];
            if (req8 && we8) mem8[addr8[9:2]] = wdata8;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) begin
            mem[i]  = '0;
            mem8[i] = '0;
        end
    endtask

    initial begin
        int n;
        rst  = 1'b0;
        rst8 = 1'b0;

        // addi r1,r0,5 ; add r2,r1,r1 ; illegal opcode 0x3F
        clearMem();
        mem[64] = 32'h20010005;
        mem[65] = 32'h00211020;
        mem[66] = 32'hFC000000;
        step(3);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_pc", pc_out, 32'h100);
        check("rst_r1", dut.regFile[1], 32'd0);
`ifdef MC_CORE_INSTRET_EN
        check("rst_instret", instret, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        step(1);
        check("first_req", {31'b0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h100);
        step(7);
        check("r2_early", dut.regFile[2], 32'd0);
        step(1);
        check("r2_add", dut.regFile[2], 32'd10);
        check("r1_addi", dut.regFile[1], 32'd5);
        check("fetch_108", mem_addr, 32'h108);
        step(1);
        check("halt_decode", {31'b0, halted}, 32'd0);
        step(1);
        check("halted", {31'b0, halted}, 32'd1);
        check("halt_req", {31'b0, mem_req}, 32'd0);
        step(5);
        check("halt_hold", {31'b0, halted}, 32'd1);
        check("halt_req_hold", {31'b0, mem_req}, 32'd0);
        check("halt_pc", pc_out, 32'h10C);
`ifdef MC_CORE_INSTRET_EN
        check("halt_instret", instret, 32'd2);
`endif
        rst = 1'b0;
        #1;
        check("rst_clr_halted", {31'b0, halted}, 32'd0);
        check("rst_clr_pc", pc_out, 32'h100);

        // addi r2,r0,10 ; sw r2,8(r0) ; lw r3,8(r0) ; halt, three wait cycles per access
        clearMem();
        mem[64] = 32'h2002000A;
        mem[65] = 32'hAC020008;
        mem[66] = 32'h8C030008;
        mem[67] = 32'hFC000000;
        waitCycles = 3;
        @(negedge clk);
        rst = 1'b1;
        step(2);
        check("wait_req", {31'b0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_access", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (!mem_we && n < 200) begin
            step(1);
            n++;
        end
        check("sw_we", {31'b0, mem_we}, 32'd1);
        check("sw_addr", mem_addr, 32'd8);
        check("sw_data", mem_wdata, 32'd10);
        n = 0;
        do begin
            step(1);
            n++;
        end while (mem_we && n < 50);
        check("sw_cycles", n, 32'd4);
        check("mem_word8", mem[2], 32'd10);
        n = 0;
        do begin
            step(1);
            n++;
        end while (dut.regFile[3] !== 32'd10 && n < 100);
        check("lw_cycles", n, 32'd11);
        check("lw_r3", dut.regFile[3], 32'd10);
        rst = 1'b0;
        waitCycles = 0;

        // beq taken, bne not taken, j, jal, jr, halt
        clearMem();
        mem[64]  = 32'h10210003;
        mem[68]  = 32'h14000007;
        mem[69]  = 32'h08000080;
        mem[128] = 32'h0C000010;
        mem[16]  = 32'h03E00008;
        mem[129] = 32'hFC000000;
        @(negedge clk);
        rst = 1'b1;
        step(4);
        check("beq_taken", mem_addr, 32'h110);
        step(3);
        check("bne_not_taken", mem_addr, 32'h114);
        step(3);
        check("j_target", mem_addr, 32'h200);
        step(3);
        check("jal_target", mem_addr, 32'h40);
        check("jal_link", dut.regFile[31], 32'h204);
        step(3);
        check("jr_target", mem_addr, 32'h204);
`ifdef MC_CORE_INSTRET_EN
        check("jump_instret", instret, 32'd5);
`endif
        step(2);
        check("halt2", {31'b0, halted}, 32'd1);

        // NREG=8: addi r9,r0,7 is dropped ; addi r1,r9,1 reads r9 as 0
        mem8[0] = 32'h20090007;
        mem8[1] = 32'h21210001;
        mem8[2] = 32'hFC000000;
        @(negedge clk);
        rst8 = 1'b1;
        step(5);
        check("n8_r1_after_r9", dut8.regFile[1], 32'd0);
        check("n8_r7", dut8.regFile[7], 32'd0);
`ifdef MC_CORE_INSTRET_EN
        check("n8_instret", instret8, 32'd1);
`endif
        step(4);
        check("n8_r9_reads_0", dut8.regFile[1], 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
